// File: rtl/control_sequencer.sv
// Instruction-cycle control decoder: turns the T0..T4 timing phases plus the latched
// instruction into datapath strobes, and tracks halt status and sticky phase errors.
module control_sequencer (
  input  logic        clk,
  input  logic        Reset,
  input  logic        T0,
  input  logic        T1,
  input  logic        T2,
  input  logic        T3,
  input  logic        T4,
  input  logic [15:0] mem_data,
  input  logic        ac_msb,
  input  logic        ac_zero,
  output logic        ar_ld,
  output logic [1:0]  ar_src,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        ir_ld,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic [2:0]  ac_op,
  output logic        sc_clr,
  output logic [15:0] ir,
  output logic [7:0]  dec,
  output logic        i_bit,
  output logic        halted,
  output logic        t_err
);

  localparam logic [1:0] SRC_PC   = 2'b00;
  localparam logic [1:0] SRC_IR   = 2'b01;
  localparam logic [1:0] SRC_MEM  = 2'b10;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_AND   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_LDA   = 3'b011;
  localparam logic [2:0] OP_CLR   = 3'b100;
  localparam logic [2:0] OP_INC   = 3'b101;

  logic [4:0] t;
  logic       phase_ok;
  logic       active;
  logic       reg_ref;
  logic       skip;
  logic       halt_now;

  assign t        = {T4, T3, T2, T1, T0};
  // Exactly one phase active: non-zero and a power of two.
  assign phase_ok = (t != 5'd0) && ((t & (t - 5'd1)) == 5'd0);
  assign active   = !halted && phase_ok;
  assign reg_ref  = dec[7] && !i_bit;
  assign skip     = (ir[4] && !ac_msb) || (ir[3] && ac_msb) || (ir[2] && ac_zero);
  assign halt_now = active && T3 && reg_ref && ir[0];

  always_comb begin
    ar_ld  = 1'b0;
    ar_src = SRC_PC;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    ir_ld  = 1'b0;
    pc_inc = 1'b0;
    pc_ld  = 1'b0;
    ac_op  = OP_NONE;
    sc_clr = 1'b0;
    if (active) begin
      if (T0) begin
        ar_ld  = 1'b1;
        ar_src = SRC_PC;
      end else if (T1) begin
        mem_rd = 1'b1;
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
      end else if (T2) begin
        ar_ld  = 1'b1;
        ar_src = SRC_IR;
      end else if (T3) begin
        if (dec[7]) begin
          sc_clr = 1'b1;
          if (!i_bit) begin
            if (ir[11])
              ac_op = OP_CLR;
            else if (ir[7])
              ac_op = OP_INC;
            pc_inc = skip;
          end
        end else if (i_bit) begin
          mem_rd = 1'b1;
          ar_ld  = 1'b1;
          ar_src = SRC_MEM;
        end
      end else begin
        // T4: memory-reference execute; a register-reference here only recovers the clear.
        sc_clr = 1'b1;
        if (!dec[7]) begin
          if (dec[0]) begin
            mem_rd = 1'b1;
            ac_op  = OP_AND;
          end else if (dec[1]) begin
            mem_rd = 1'b1;
            ac_op  = OP_ADD;
          end else if (dec[2]) begin
            mem_rd = 1'b1;
            ac_op  = OP_LDA;
          end else if (dec[3]) begin
            mem_wr = 1'b1;
          end else if (dec[4]) begin
            pc_ld  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      ir     <= 16'h0000;
      dec    <= 8'h00;
      i_bit  <= 1'b0;
      halted <= 1'b0;
      t_err  <= 1'b0;
    end else begin
      if (!halted && !phase_ok)
        t_err <= 1'b1;
      if (ir_ld)
        ir <= mem_data;
      if (active && T2) begin
        dec   <= 8'd1 << ir[14:12];
        i_bit <= ir[15];
      end
      if (halt_now)
        halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks instructions through T0..T4 and compares
// strobes and registered state against hand-computed values.
module tb_control_sequencer;

  logic        clk;
  logic        Reset;
  logic [4:0]  tv;
  logic [15:0] mem_data;
  logic        ac_msb;
  logic        ac_zero;
  logic        ar_ld;
  logic [1:0]  ar_src;
  logic        mem_rd;
  logic        mem_wr;
  logic        ir_ld;
  logic        pc_inc;
  logic        pc_ld;
  logic [2:0]  ac_op;
  logic        sc_clr;
  logic [15:0] ir;
  logic [7:0]  dec;
  logic        i_bit;
  logic        halted;
  logic        t_err;

  int total = 0;
  int bad   = 0;

  control_sequencer dut (
    .clk      (clk),
    .Reset    (Reset),
    .T0       (tv[0]),
    .T1       (tv[1]),
    .T2       (tv[2]),
    .T3       (tv[3]),
    .T4       (tv[4]),
    .mem_data (mem_data),
    .ac_msb   (ac_msb),
    .ac_zero  (ac_zero),
    .ar_ld    (ar_ld),
    .ar_src   (ar_src),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .ir_ld    (ir_ld),
    .pc_inc   (pc_inc),
    .pc_ld    (pc_ld),
    .ac_op    (ac_op),
    .sc_clr   (sc_clr),
    .ir       (ir),
    .dec      (dec),
    .i_bit    (i_bit),
    .halted   (halted),
    .t_err    (t_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed control word: {ar_ld, ar_src, mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, ac_op, sc_clr}
  function automatic logic [11:0] mk(input logic a_ld, input logic [1:0] src, input logic rd,
                                     input logic wr, input logic irl, input logic pci,
                                     input logic pcl, input logic [2:0] op, input logic clr);
    return {a_ld, src, rd, wr, irl, pci, pcl, op, clr};
  endfunction

  function automatic logic [11:0] ctl();
    return {ar_ld, ar_src, mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, ac_op, sc_clr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply a phase vector at the falling edge; combinational outputs settle 1 ns later.
  task automatic phase(input logic [4:0] p);
    @(negedge clk);
    tv = p;
    #1;
  endtask

  task automatic fetch(input string tag, input logic [15:0] word);
    phase(5'b00001);
    chk({tag, " T0"}, ctl(), mk(1, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));
    mem_data = word;
    phase(5'b00010);
    chk({tag, " T1"}, ctl(), mk(0, 2'b00, 1, 0, 1, 1, 0, 3'b000, 0));
    phase(5'b00100);
    chk({tag, " T2"}, ctl(), mk(1, 2'b01, 0, 0, 0, 0, 0, 3'b000, 0));
    chk({tag, " ir"}, ir, word);
  endtask

  initial begin
    Reset    = 1'b1;
    tv       = 5'b00001;
    mem_data = 16'h0000;
    ac_msb   = 1'b0;
    ac_zero  = 1'b0;
    #12;
    chk("rst ir", ir, 16'h0000);
    chk("rst dec", dec, 8'h00);
    chk("rst flags", {i_bit, halted, t_err}, 3'b000);

    // Release reset with T0 already active
    @(negedge clk);
    Reset = 1'b0;
    #1;
    chk("post-rst T0", ctl(), mk(1, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));

    // LDA direct
    fetch("lda", 16'h2123);
    phase(5'b01000);
    chk("lda dec", dec, 8'h04);
    chk("lda ibit", i_bit, 1'b0);
    chk("lda T3", ctl(), 12'h000);
    phase(5'b10000);
    chk("lda T4", ctl(), mk(0, 2'b00, 1, 0, 0, 0, 0, 3'b011, 1));

    // ADD indirect
    fetch("add", 16'h9050);
    phase(5'b01000);
    chk("add dec", dec, 8'h02);
    chk("add ibit", i_bit, 1'b1);
    chk("add T3", ctl(), mk(1, 2'b10, 1, 0, 0, 0, 0, 3'b000, 0));
    phase(5'b10000);
    chk("add T4", ctl(), mk(0, 2'b00, 1, 0, 0, 0, 0, 3'b010, 1));

    // STA and BUN
    fetch("sta", 16'h3200);
    phase(5'b01000);
    phase(5'b10000);
    chk("sta T4", ctl(), mk(0, 2'b00, 0, 1, 0, 0, 0, 3'b000, 1));
    fetch("bun", 16'h4010);
    phase(5'b01000);
    phase(5'b10000);
    chk("bun T4", ctl(), mk(0, 2'b00, 0, 0, 0, 0, 1, 3'b000, 1));

    // SZA with ac_zero set, then clear; T4 after a register reference only clears
    fetch("sza1", 16'h7004);
    ac_zero = 1'b1;
    phase(5'b01000);
    chk("sza dec", dec, 8'h80);
    chk("sza1 T3", ctl(), mk(0, 2'b00, 0, 0, 0, 1, 0, 3'b000, 1));
    ac_zero = 1'b0;
    #1;
    chk("sza0 T3", ctl(), mk(0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1));
    phase(5'b10000);
    chk("rr T4", ctl(), mk(0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1));

    // CLA+INC together: CLA wins; SPA skips on positive AC
    fetch("cla", 16'h7890);
    ac_msb = 1'b0;
    phase(5'b01000);
    chk("cla T3", ctl(), mk(0, 2'b00, 0, 0, 0, 1, 0, 3'b100, 1));
    ac_msb = 1'b1;
    #1;
    chk("spa neg T3", ctl(), mk(0, 2'b00, 0, 0, 0, 0, 0, 3'b100, 1));
    ac_msb = 1'b0;

    // I/O instruction at T3
    fetch("io", 16'hF040);
    phase(5'b01000);
    chk("io T3", ctl(), mk(0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1));

    // HLT
    fetch("hlt", 16'h7001);
    phase(5'b01000);
    chk("hlt T3", ctl(), mk(0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1));
    chk("hlt pre", halted, 1'b0);
    phase(5'b00001);
    chk("halted", halted, 1'b1);
    chk("halt T0", ctl(), 12'h000);
    mem_data = 16'h2123;
    phase(5'b00010);
    chk("halt T1", ctl(), 12'h000);
    phase(5'b00000);
    chk("halt ir hold", ir, 16'h7001);
    phase(5'b00100);
    chk("halt no terr", t_err, 1'b0);
    chk("halt dec hold", dec, 8'h80);
    Reset = 1'b1;
    #1;
    chk("hlt rst", halted, 1'b0);
    tv = 5'b00001;
    @(negedge clk);
    Reset = 1'b0;

    // Phase error: T0 and T1 together
    phase(5'b00011);
    chk("perr ctl", ctl(), 12'h000);
    chk("perr pre", t_err, 1'b0);
    phase(5'b00001);
    chk("perr sticky1", t_err, 1'b1);
    chk("perr recover T0", ctl(), mk(1, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));
    phase(5'b00010);
    chk("perr sticky2", t_err, 1'b1);
    Reset = 1'b1;
    #1;
    chk("perr rst", t_err, 1'b0);
    tv = 5'b00001;
    @(negedge clk);
    Reset = 1'b0;

    // Reset mid-instruction during T2
    fetch("mid", 16'h3200);
    Reset = 1'b1;
    #1;
    chk("mid ir", ir, 16'h0000);
    chk("mid dec", dec, 8'h00);
    @(negedge clk);
    tv    = 5'b00001;
    Reset = 1'b0;
    #1;
    chk("mid T0", ctl(), mk(1, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 T0..T4  input  1 each  one-hot timing phases from the sequence counter.
REQ-004 mem_data  input  16  memory read data; format [15]=I, [14:12]=opcode, [11:0]=address.
REQ-005 ac_msb, ac_zero  input  1 each  accumulator sign bit and zero flag.
REQ-006 ar_ld  output  1  load AR.
REQ-007 ar_src  output  2  AR source: 00=PC, 01=ir[11:0], 10=mem_data[11:0].
REQ-008 mem_rd, mem_wr  output  1 each  memory read and write strobes.
REQ-009 ir_ld, pc_inc, pc_ld  output  1 each  IR load, PC increment, PC load from AR.
REQ-010 ac_op  output  3  000=none, 001=AND, 010=ADD, 011=LDA, 100=CLR, 101=INC.
REQ-011 sc_clr  output  1  clear request to the sequence counter.
REQ-012 ir  output  16  latched instruction.
REQ-013 dec  output  8  registered one-hot opcode decode D7..D0.
REQ-014 i_bit, halted, t_err  output  1 each  indirect flag, halt status, sticky phase error.

Function
REQ-015 Control outputs SHALL be combinational from T0..T4 and registered state, valid within the phase cycle; the datapath samples them on the next rising edge.
REQ-016 When halted=1, all control outputs (ar_ld, mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, sc_clr) SHALL be 0, ac_op=000, and ir/dec/i_bit SHALL hold.
REQ-017 T0: ar_ld=1, ar_src=00; no other strobe asserted.
REQ-018 T1: mem_rd=1, ir_ld=1, pc_inc=1; at the T1 clock edge, ir <= mem_data.
REQ-019 T2: ar_ld=1, ar_src=01; at the T2 edge, dec <= one-hot(ir[14:12]) and i_bit <= ir[15].
REQ-020 T3, dec[7]=1, i_bit=0 (register-reference): sc_clr=1; ir[11] -> ac_op=100; else ir[7] -> ac_op=101 (CLA has priority over INC).
REQ-021 T3 register-reference skip: pc_inc=1 if (ir[4] & ~ac_msb) | (ir[3] & ac_msb) | (ir[2] & ac_zero); multiple skip bits are ORed.
REQ-022 T3 register-reference with ir[0]=1: halted set at the T3 edge; that cycle's sc_clr, ac_op and pc_inc still asserted.
REQ-023 T3, dec[7]=1, i_bit=1 (I/O): no-op, sc_clr=1 only.
REQ-024 T3, dec[7]=0, i_bit=1: mem_rd=1, ar_ld=1, ar_src=10 (indirect address fetch).
REQ-025 T3, dec[7]=0, i_bit=0: no strobes.
REQ-026 T4 (dec[7]=0 only), sc_clr=1 plus: D0 mem_rd, ac_op=001; D1 mem_rd, ac_op=010; D2 mem_rd, ac_op=011; D3 mem_wr; D4 pc_ld; D5, D6 no-op.
REQ-027 T4 with dec[7]=1 SHALL assert sc_clr=1 only (recovery for a missed T3 clear).
REQ-028 t_err SHALL be set at any rising edge with halted=0 where the count of active T inputs != 1; it is cleared only by Reset.
REQ-029 With a phase error (none or more than one T input active), all control outputs SHALL be 0 in that cycle.
REQ-030 ir, dec and i_bit SHALL update only on their designated phase edge (T1, T2) and never while halted.

Reset
REQ-031 On Reset: ir=16'h0000, dec=8'h00, i_bit=0, halted=0, t_err=0; asynchronous, effective immediately mid-instruction.
REQ-032 After Reset deasserts with T0=1, ar_ld=1, ar_src=00 in the same cycle.

Verification
REQ-033 LDA direct: mem_data=16'h2123 at T1 -> ir=16'h2123; after T2, dec=8'h04, i_bit=0; T3 no strobes; T4 mem_rd=1, ac_op=011, sc_clr=1.
REQ-034 ADD indirect: mem_data=16'h9050 -> dec=8'h02, i_bit=1; T3 mem_rd=1, ar_ld=1, ar_src=10; T4 ac_op=010, sc_clr=1.
REQ-035 SZA: ir=16'h7004 with ac_zero=1 -> T3 pc_inc=1, sc_clr=1; with ac_zero=0 -> pc_inc=0, sc_clr=1.
REQ-036 HLT: ir=16'h7001 -> halted=1 after the T3 edge; subsequent T0..T4 produce all-zero controls; Reset -> halted=0.
REQ-037 Phase error: drive T0=T1=1 for one cycle -> all controls 0 that cycle and t_err=1 sticky until Reset.
REQ-038 Reset mid-instruction: assert Reset during T2 of 16'h3200 -> ir=0, dec=0 immediately; next T0 gives ar_ld=1, ar_src=00.
